// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver in the system clock domain: pin conditioning, 11-bit framing with
// parity/stop/timeout checks, optional E0/F0 folding, and a first-word-fall-through FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned DECODE_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2Clk,
  input  logic                          ps2Dat,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    data,
  output logic                          brk,
  output logic                          ext,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned EW = 10;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          fclk, flip_c, fall_c;
  logic [FW-1:0] fcnt;

  state_t        state, state_nx;
  logic [3:0]    bitcnt, bitcnt_nx;
  logic [9:0]    shreg, shreg_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          timeout_c;

  logic          par_ok_c, stop_ok_c, valid_c, perr_c, ferr_c;
  logic [7:0]    byte_c;
  logic          ext_p, brk_p, ext_p_nx, brk_p_nx;
  logic          push_c, pop_c, wr_c, ovf_c;
  logic [EW-1:0] entry_c, head_nx, head;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] remain_c, count_nx;

  // Two-flop synchronisers for both pins
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2Clk};
      dat_sync <= {dat_sync[0], ps2Dat};
    end
  end

  // Level filter: fclk follows only after FILTER_LEN consecutive differing samples
  assign flip_c = (clk_sync[1] != fclk) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall_c = flip_c && fclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      fclk <= 1'b1;
      fcnt <= '0;
    end else if (clk_sync[1] == fclk) begin
      fcnt <= '0;
    end else if (flip_c) begin
      fclk <= ~fclk;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  // Frame FSM: shreg collects data[7:0], parity, stop LSB-first
  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    tcnt_nx   = tcnt;
    timeout_c = 1'b0;
    unique case (state)
      IDLE: begin
        tcnt_nx = '0;
        if (fall_c && !dat_sync[1]) begin
          state_nx  = RECV;
          bitcnt_nx = 4'd1;
        end
      end
      RECV: begin
        if (fall_c) begin
          shreg_nx  = {dat_sync[1], shreg[9:1]};
          bitcnt_nx = bitcnt + 4'd1;
          tcnt_nx   = '0;
          if (bitcnt == 4'd10) state_nx = CHECK;
        end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
          timeout_c = 1'b1;
          state_nx  = IDLE;
          bitcnt_nx = '0;
          tcnt_nx   = '0;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      CHECK: begin
        state_nx  = IDLE;
        bitcnt_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame check, prefix decode and FIFO bookkeeping
  always_comb begin
    par_ok_c  = ^shreg[8:0];
    stop_ok_c = shreg[9];
    byte_c    = shreg[7:0];
    perr_c    = (state == CHECK) && !par_ok_c;
    ferr_c    = ((state == CHECK) && !stop_ok_c) || timeout_c;
    valid_c   = (state == CHECK) && par_ok_c && stop_ok_c;
    push_c    = 1'b0;
    entry_c   = {ext_p, brk_p, byte_c};
    ext_p_nx  = ext_p;
    brk_p_nx  = brk_p;
    if (valid_c) begin
      if (DECODE_MODE == 0) begin
        push_c  = 1'b1;
        entry_c = {2'b00, byte_c};
      end else if (byte_c == 8'hE0) begin
        ext_p_nx = 1'b1;
      end else if (byte_c == 8'hF0) begin
        brk_p_nx = 1'b1;
      end else begin
        push_c   = 1'b1;
        ext_p_nx = 1'b0;
        brk_p_nx = 1'b0;
      end
    end
    pop_c     = rd_en && !empty;
    wr_c      = push_c && (!full || pop_c);
    ovf_c     = push_c && full && !pop_c;
    rd_ptr_nx = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    remain_c  = count - (pop_c ? CW'(1) : CW'(0));
    count_nx  = remain_c + (wr_c ? CW'(1) : CW'(0));
    if (count_nx == '0)      head_nx = '0;
    else if (remain_c == '0) head_nx = entry_c;
    else                     head_nx = mem[rd_ptr_nx];
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= entry_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      tcnt       <= '0;
      ext_p      <= 1'b0;
      brk_p      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      head       <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      bitcnt     <= bitcnt_nx;
      shreg      <= shreg_nx;
      tcnt       <= tcnt_nx;
      ext_p      <= ext_p_nx;
      brk_p      <= brk_p_nx;
      wr_ptr     <= wr_c ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr     <= rd_ptr_nx;
      count      <= count_nx;
      empty      <= (count_nx == '0);
      full       <= (count_nx == CW'(FIFO_DEPTH));
      head       <= head_nx;
      // an error event in the same cycle as clr_err wins
      err_parity <= perr_c | (err_parity & ~clr_err);
      err_frame  <= ferr_c | (err_frame & ~clr_err);
      overflow   <= ovf_c  | (overflow & ~clr_err);
    end
  end

  assign {ext, brk, data} = head;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: one mode-1 and one mode-0 instance share the PS/2 pins;
// a queue-based model of the received entries and sticky flags is compared every settled cycle.
module tb_ps2_rx_fifo;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned FLT   = 4;
  localparam int unsigned TMO   = 300;
  localparam int unsigned H     = 10;

  logic clk = 1'b0;
  logic reset, ps2Clk, ps2Dat, rd_en, clr_err;
  logic [7:0] d1, d0;
  logic b1, b0, x1, x0, e1, e0, f1, f0, p1, p0, fr1, fr0, o1, o0;
  logic [3:0] c1, c0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO), .DECODE_MODE(1)) u1 (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Dat(ps2Dat), .rd_en(rd_en), .clr_err(clr_err),
    .data(d1), .brk(b1), .ext(x1), .empty(e1), .full(f1), .count(c1),
    .err_parity(p1), .err_frame(fr1), .overflow(o1));

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO), .DECODE_MODE(0)) u0 (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Dat(ps2Dat), .rd_en(rd_en), .clr_err(clr_err),
    .data(d0), .brk(b0), .ext(x0), .empty(e0), .full(f0), .count(c0),
    .err_parity(p0), .err_frame(fr0), .overflow(o0));

  int checks = 0;
  int errors = 0;
  logic settled = 1'b0;

  // Model: expected FIFO contents {ext,brk,byte} per instance, prefixes and sticky flags
  logic [9:0] q1[$];
  logic [9:0] q0[$];
  logic mext, mbrk, mperr, mferr, mov1, mov0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q1.delete(); q0.delete();
    mext = 0; mbrk = 0; mperr = 0; mferr = 0; mov1 = 0; mov0 = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
    logic podd;
    podd = ^{b, par};
    if (!podd || !stop) begin
      if (!podd) mperr = 1;
      if (!stop) mferr = 1;
    end else begin
      if (q0.size() == DEPTH) mov0 = 1; else q0.push_back({2'b00, b});
      if (b == 8'hE0) mext = 1;
      else if (b == 8'hF0) mbrk = 1;
      else begin
        if (q1.size() == DEPTH) mov1 = 1; else q1.push_back({mext, mbrk, b});
        mext = 0; mbrk = 0;
      end
    end
  endtask

  // Per-cycle comparison against the model while no frame is in flight
  always @(negedge clk) begin
    if (settled) begin
      automatic logic [9:0] h1 = (q1.size() != 0) ? q1[0] : 10'h0;
      automatic logic [9:0] h0 = (q0.size() != 0) ? q0[0] : 10'h0;
      chk("m1_head",  {x1, b1, d1}, h1);
      chk("m1_count", c1, q1.size());
      chk("m1_empty", e1, q1.size() == 0);
      chk("m1_full",  f1, q1.size() == DEPTH);
      chk("m1_perr",  p1, mperr);
      chk("m1_ferr",  fr1, mferr);
      chk("m1_ovf",   o1, mov1);
      chk("m0_head",  {x0, b0, d0}, h0);
      chk("m0_count", c0, q0.size());
      chk("m0_empty", e0, q0.size() == 0);
      chk("m0_full",  f0, q0.size() == DEPTH);
      chk("m0_perr",  p0, mperr);
      chk("m0_ferr",  fr0, mferr);
      chk("m0_ovf",   o0, mov0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic send(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    settled = 0;
    for (int i = 0; i < 11; i++) begin
      ps2Dat = f[i]; cyc(H);
      ps2Clk = 0;    cyc(H);
      ps2Clk = 1;
    end
    ps2Dat = 1;
    cyc(30);
    model_frame(b, par, stop);
    settled = 1;
  endtask

  // Start bit plus (n-1) random bits, then the line goes quiet
  task automatic send_partial(input int n);
    settled = 0;
    for (int i = 0; i < n; i++) begin
      ps2Dat = (i == 0) ? 1'b0 : 1'($urandom_range(1, 0)); cyc(H);
      ps2Clk = 0; cyc(H);
      ps2Clk = 1;
    end
    ps2Dat = 1;
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1;
    @(posedge clk);
    if (q1.size() != 0) void'(q1.pop_front());
    if (q0.size() != 0) void'(q0.pop_front());
    #1 rd_en = 0;
  endtask

  task automatic clr();
    @(negedge clk);
    clr_err = 1;
    @(posedge clk);
    mperr = 0; mferr = 0; mov1 = 0; mov0 = 0;
    #1 clr_err = 0;
  endtask

  task automatic do_reset();
    settled = 0;
    reset = 1;
    cyc(3);
    reset = 0;
    model_reset();
    cyc(2);
    settled = 1;
  endtask

  initial begin
    reset = 1; ps2Clk = 1; ps2Dat = 1; rd_en = 0; clr_err = 0;
    model_reset();
    cyc(1);
    do_reset();
    chk("rst_empty", e1, 1);
    chk("rst_count", c1, 0);
    chk("rst_data", d1, 0);
    chk("rst_flags", {p1, fr1, o1}, 0);

    // clean frame
    send(8'h1C, good_par(8'h1C), 1);
    chk("lit_1c_data", {x1, b1, d1}, 10'h01C);
    chk("lit_1c_count", c1, 1);
    pop();
    chk("lit_1c_popped", e1, 1);

    // prefix folding vs raw
    send(8'hE0, good_par(8'hE0), 1);
    send(8'hF0, good_par(8'hF0), 1);
    send(8'h75, good_par(8'h75), 1);
    chk("lit_fold", {x1, b1, d1}, 10'h375);
    chk("lit_fold_cnt", c1, 1);
    chk("lit_raw_cnt", c0, 3);
    chk("lit_raw0", {x0, b0, d0}, 10'h0E0);
    pop();
    chk("lit_raw1", {x0, b0, d0}, 10'h0F0);
    pop();
    chk("lit_raw2", {x0, b0, d0}, 10'h075);
    pop();

    // parity and stop errors
    send(8'h1C, 1'b1, 1);
    chk("lit_perr", p1, 1);
    chk("lit_perr_empty", e1, 1);
    clr();
    chk("lit_perr_clr", p1, 0);
    send(8'h55, good_par(8'h55), 0);
    chk("lit_stop_err", fr1, 1);
    clr();

    // sub-filter glitch with data low: must not start a frame
    ps2Dat = 0; ps2Clk = 0; cyc(2);
    ps2Clk = 1; ps2Dat = 1;
    cyc(TMO + 40);
    chk("lit_glitch", {fr1, e1}, 2'b01);

    // timeout, then an intact frame
    send_partial(5);
    cyc(TMO + 40);
    mferr = 1;
    settled = 1;
    chk("lit_timeout", fr1, 1);
    send(8'h29, good_par(8'h29), 1);
    chk("lit_after_tmo", d1, 8'h29);
    pop();
    clr();

    // reset in the middle of a frame
    send_partial(5);
    do_reset();
    chk("lit_midrst", {e1, c1, d1, p1, fr1, o1}, {1'b1, 4'd0, 8'd0, 3'b000});
    send(8'h1C, good_par(8'h1C), 1);
    chk("lit_midrst_1c", d1, 8'h1C);
    pop();

    // overflow with DEPTH+1 frames
    for (int i = 1; i <= DEPTH + 1; i++) send(8'(i), good_par(8'(i)), 1);
    chk("lit_full", f1, 1);
    chk("lit_ovf", o1, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("lit_ovf_rd", d0, 32'(i));
      pop();
    end
    chk("lit_ovf_drained", e0, 1);
    clr();

    // randomized traffic
    for (int n = 0; n < 120; n++) begin
      automatic int r = $urandom_range(9, 0);
      automatic logic [7:0] b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      automatic logic par = good_par(b) ^ ($urandom_range(7, 0) == 0);
      automatic logic stop = ($urandom_range(9, 0) != 0);
      send(b, par, stop);
      if ($urandom_range(2, 0) == 0) pop();
      if ($urandom_range(3, 0) == 0) pop();
      if ($urandom_range(9, 0) == 0) clr();
    end
    for (int i = 0; i < DEPTH; i++) pop();
    cyc(4);
    settled = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
